// File: rtl/bids_n_auction_if.sv
// rtl/bids_n_auction_if.sv - host control and bidder signal bundle for bids_n_auction
interface bids_n_auction_if #(
  parameter int NUM_BIDDERS = 3,
  parameter int AMT_W       = 16,
  parameter int BAL_W       = 32
);
  logic [NUM_BIDDERS-1:0]       bid;
  logic [NUM_BIDDERS-1:0]       retract;
  logic [NUM_BIDDERS*AMT_W-1:0] bid_amt;
  logic                         c_start;
  logic [3:0]                   c_op;
  logic [31:0]                  c_data;
  logic [NUM_BIDDERS-1:0]       ack;
  logic [NUM_BIDDERS*2-1:0]     bidder_err;
  logic [NUM_BIDDERS-1:0]       win;
  logic [NUM_BIDDERS*BAL_W-1:0] balance;
  logic [AMT_W-1:0]             max_bid;
  logic                         ready;
  logic                         round_over;
  logic [2:0]                   err;

  modport master (
    output bid, retract, bid_amt, c_start, c_op, c_data,
    input  ack, bidder_err, win, balance, max_bid, ready, round_over, err
  );

  modport slave (
    input  bid, retract, bid_amt, c_start, c_op, c_data,
    output ack, bidder_err, win, balance, max_bid, ready, round_over, err
  );
endinterface

// File: rtl/bids_n_auction.sv
// rtl/bids_n_auction.sv - N-bidder sealed-bid auction controller with timeout and tie detection
module bids_n_auction #(
  parameter int          NUM_BIDDERS = 3,
  parameter int          AMT_W       = 16,
  parameter int          BAL_W       = 32,
  parameter logic [31:0] UNLOCK_KEY  = 32'h0F0F0F0F
) (
  input logic             clk,
  input logic             reset_n,
  bids_n_auction_if.slave bus
);
  localparam int SEL_W = (NUM_BIDDERS > 1) ? $clog2(NUM_BIDDERS) : 1;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_SEL    = 4'd3;
  localparam logic [3:0] OP_LDBAL  = 4'd4;
  localparam logic [3:0] OP_MASK   = 4'd5;
  localparam logic [3:0] OP_TIMER  = 4'd6;
  localparam logic [3:0] OP_COST   = 4'd7;

  typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_ROUND, ST_RESULT} state_t;

  state_t                   state_q, state_d;
  logic [31:0]              key_q, key_d;
  logic [NUM_BIDDERS-1:0]   mask_q, mask_d;
  logic [31:0]              timer_cfg_q, timer_cfg_d;
  logic [31:0]              countdown_q, countdown_d;
  logic [BAL_W-1:0]         bid_cost_q, bid_cost_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [BAL_W-1:0]         bal_q [NUM_BIDDERS];
  logic [BAL_W-1:0]         bal_d [NUM_BIDDERS];
  logic [AMT_W-1:0]         cur_q [NUM_BIDDERS];
  logic [AMT_W-1:0]         cur_d [NUM_BIDDERS];
  logic [NUM_BIDDERS-1:0]   ack_q, ack_d;
  logic [NUM_BIDDERS*2-1:0] berr_q, berr_d;
  logic [NUM_BIDDERS-1:0]   win_q, win_d;
  logic [AMT_W-1:0]         max_bid_q, max_bid_d;
  logic                     ready_q, ready_d;
  logic                     round_over_q, round_over_d;
  logic [2:0]               err_q, err_d;

  logic [AMT_W-1:0]         amt_v  [NUM_BIDDERS];
  logic [BAL_W:0]           need_v [NUM_BIDDERS];
  logic [AMT_W-1:0]         max_v;
  logic [4:0]               n_top;
  logic [NUM_BIDDERS-1:0]   top_oh;

  // Unpack bid amounts and form the affordability threshold one bit wider than a balance
  always_comb begin
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      amt_v[i]  = bus.bid_amt[i*AMT_W +: AMT_W];
      need_v[i] = {1'b0, bid_cost_q} + (BAL_W+1)'(amt_v[i]);
    end
  end

  // Highest standing bid, how many bidders hold it, and which ones
  always_comb begin
    max_v  = '0;
    n_top  = '0;
    top_oh = '0;
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (cur_q[i] > max_v) max_v = cur_q[i];
    end
    for (int i = 0; i < NUM_BIDDERS; i++) begin
      if (cur_q[i] == max_v) begin
        n_top     = n_top + 5'd1;
        top_oh[i] = 1'b1;
      end
    end
  end

  // Next-state and registered-output decisions for every state
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    mask_d       = mask_q;
    timer_cfg_d  = timer_cfg_q;
    countdown_d  = countdown_q;
    bid_cost_d   = bid_cost_q;
    sel_d        = sel_q;
    bal_d        = bal_q;
    cur_d        = cur_q;
    win_d        = win_q;
    max_bid_d    = max_bid_q;
    ack_d        = '0;
    berr_d       = '0;
    round_over_d = 1'b0;
    err_d        = 3'd0;

    case (state_q)
      ST_UNLOCKED: begin
        case (bus.c_op)
          OP_NOP:    ;
          OP_UNLOCK: err_d = 3'd2;
          OP_LOCK: begin
            key_d   = bus.c_data;
            state_d = ST_LOCKED;
          end
          OP_SEL: begin
            if (bus.c_data < 32'(NUM_BIDDERS)) sel_d = bus.c_data[SEL_W-1:0];
            else                               err_d = 3'd4;
          end
          OP_LDBAL: bal_d[sel_q] = bus.c_data[BAL_W-1:0];
          OP_MASK:  mask_d       = bus.c_data[NUM_BIDDERS-1:0];
          OP_TIMER: timer_cfg_d  = bus.c_data;
          OP_COST:  bid_cost_d   = bus.c_data[BAL_W-1:0];
          default:  err_d        = 3'd4;
        endcase
        // A stray round start outranks any op error, but the op still takes effect
        if (bus.c_start) err_d = 3'd3;
      end

      ST_LOCKED: begin
        for (int i = 0; i < NUM_BIDDERS; i++) begin
          if (bus.bid[i] || bus.retract[i]) berr_d[2*i +: 2] = 2'd1;
        end
        if (bus.c_op == OP_UNLOCK) begin
          if (bus.c_data == key_q) state_d = ST_UNLOCKED;
          else                     err_d   = 3'd1;
        end else begin
          if (bus.c_op != OP_NOP) err_d = 3'd4;
          if (bus.c_start) begin
            state_d     = ST_ROUND;
            countdown_d = timer_cfg_q;
            win_d       = '0;
            for (int i = 0; i < NUM_BIDDERS; i++) cur_d[i] = '0;
          end
        end
      end

      ST_ROUND: begin
        if (countdown_q != 32'd0) countdown_d = countdown_q - 32'd1;
        if (!bus.c_start || countdown_q == 32'd1) begin
          state_d = ST_RESULT;
        end else begin
          for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (bus.retract[i]) begin
              cur_d[i] = '0;
            end else if (bus.bid[i]) begin
              if (!mask_q[i]) begin
                berr_d[2*i +: 2] = 2'd3;
              end else if ({1'b0, bal_q[i]} >= need_v[i]) begin
                bal_d[i] = bal_q[i] - bid_cost_q;
                cur_d[i] = amt_v[i];
                ack_d[i] = 1'b1;
              end else begin
                berr_d[2*i +: 2] = 2'd2;
              end
            end
          end
        end
      end

      ST_RESULT: begin
        round_over_d = 1'b1;
        state_d      = ST_LOCKED;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
          if (bus.bid[i] || bus.retract[i]) berr_d[2*i +: 2] = 2'd1;
        end
        if (max_v == '0) begin
          max_bid_d = '0;
          win_d     = '0;
        end else if (n_top > 5'd1) begin
          err_d     = 3'd5;
          max_bid_d = max_v;
          win_d     = '0;
        end else begin
          max_bid_d = max_v;
          win_d     = top_oh;
          for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (top_oh[i]) bal_d[i] = bal_q[i] - BAL_W'(max_v);
          end
        end
      end

      default: state_d = ST_UNLOCKED;
    endcase

    ready_d = (state_d == ST_UNLOCKED) || (state_d == ST_LOCKED);
  end

  // State and output registers; reset drops everything including partial round charges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_UNLOCKED;
      key_q        <= UNLOCK_KEY;
      mask_q       <= '1;
      timer_cfg_q  <= '0;
      countdown_q  <= '0;
      bid_cost_q   <= BAL_W'(1);
      sel_q        <= '0;
      for (int i = 0; i < NUM_BIDDERS; i++) begin
        bal_q[i] <= '0;
        cur_q[i] <= '0;
      end
      ack_q        <= '0;
      berr_q       <= '0;
      win_q        <= '0;
      max_bid_q    <= '0;
      ready_q      <= 1'b0;
      round_over_q <= 1'b0;
      err_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      mask_q       <= mask_d;
      timer_cfg_q  <= timer_cfg_d;
      countdown_q  <= countdown_d;
      bid_cost_q   <= bid_cost_d;
      sel_q        <= sel_d;
      bal_q        <= bal_d;
      cur_q        <= cur_d;
      ack_q        <= ack_d;
      berr_q       <= berr_d;
      win_q        <= win_d;
      max_bid_q    <= max_bid_d;
      ready_q      <= ready_d;
      round_over_q <= round_over_d;
      err_q        <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_BIDDERS; g++) begin : g_bal
    assign bus.balance[g*BAL_W +: BAL_W] = bal_q[g];
  end

  assign bus.ack        = ack_q;
  assign bus.bidder_err = berr_q;
  assign bus.win        = win_q;
  assign bus.max_bid    = max_bid_q;
  assign bus.ready      = ready_q;
  assign bus.round_over = round_over_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_bids_n_auction.sv
// tb/tb_bids_n_auction.sv - directed vector bench for bids_n_auction
module tb_bids_n_auction;
  localparam logic [3:0] NOP = 4'd0, UNL = 4'd1, LCK = 4'd2, SEL = 4'd3;
  localparam logic [3:0] LDB = 4'd4, MSK = 4'd5, TMR = 4'd6;

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] d;
    logic        st;
    logic [2:0]  b;
    logic [2:0]  r;
    logic [47:0] amt;
    logic [2:0]  e;
    logic [2:0]  ak;
    logic [5:0]  be;
    logic [2:0]  w;
    logic [15:0] mb;
    logic        rd;
    logic        ro;
    logic [31:0] b0, b1, b2;
  } vec_t;

  logic clk = 1'b0;
  logic rst3_n = 1'b0;
  logic rst8_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  bids_n_auction_if #(.NUM_BIDDERS(3), .AMT_W(16), .BAL_W(32)) if3 ();
  bids_n_auction_if #(.NUM_BIDDERS(8), .AMT_W(8),  .BAL_W(16)) if8 ();

  bids_n_auction #(.NUM_BIDDERS(3), .AMT_W(16), .BAL_W(32)) dut3 (
    .clk(clk), .reset_n(rst3_n), .bus(if3)
  );
  bids_n_auction #(.NUM_BIDDERS(8), .AMT_W(8), .BAL_W(16)) dut8 (
    .clk(clk), .reset_n(rst8_n), .bus(if8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] a3(input int x2, input int x1, input int x0);
    return {16'(x2), 16'(x1), 16'(x0)};
  endfunction

  task automatic av(input string nm, input logic [3:0] op, input logic [31:0] d,
                    input logic st, input logic [2:0] b, input logic [2:0] r,
                    input logic [47:0] amt, input logic [2:0] e, input logic [2:0] ak,
                    input logic [5:0] be, input logic [2:0] w, input logic [15:0] mb,
                    input logic rd, input logic ro,
                    input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
    vec_t v;
    v.nm = nm; v.op = op; v.d = d; v.st = st; v.b = b; v.r = r; v.amt = amt;
    v.e = e; v.ak = ak; v.be = be; v.w = w; v.mb = mb; v.rd = rd; v.ro = ro;
    v.b0 = b0; v.b1 = b1; v.b2 = b2;
    vq.push_back(v);
  endtask

  task automatic drive8(input logic [3:0] op, input logic [31:0] d, input logic st,
                        input logic [7:0] b, input logic [63:0] amt);
    if8.c_op = op; if8.c_data = d; if8.c_start = st;
    if8.bid = b; if8.retract = '0; if8.bid_amt = amt;
  endtask

  initial begin
    if3.c_op = NOP; if3.c_data = '0; if3.c_start = 1'b0;
    if3.bid = '0; if3.retract = '0; if3.bid_amt = '0;
    drive8(NOP, 0, 1'b0, 8'h00, 64'h0);

    //        name          op   data st  bid    ret    amt             err ack  berr       win    mb rd ro  bal0 bal1 bal2
    av("nop",        NOP, 0,   0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 0,   0,   0);
    av("sel0",       SEL, 0,   0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 0,   0,   0);
    av("ld0",        LDB, 100, 0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 100, 0,   0);
    av("sel1",       SEL, 1,   0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 100, 0,   0);
    av("ld1",        LDB, 100, 0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 100, 100, 0);
    av("sel2",       SEL, 2,   0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 100, 100, 0);
    av("ld2",        LDB, 100, 0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("sel_oob",    SEL, 3,   0, 0,     0,     0,              4, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("bad_op",     4'd9, 0,  0, 0,     0,     0,              4, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("unl_unl",    UNL, 0,   0, 0,     0,     0,              2, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("start_unl",  NOP, 0,   1, 0,     0,     0,              3, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("lock5",      LCK, 5,   0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("bad_key",    UNL, 6,   0, 0,     0,     0,              1, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("op_locked",  SEL, 0,   0, 0,     0,     0,              4, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("bid_locked", NOP, 0,   0, 3'b001, 0,    0,              0, 0,     6'b000001, 0,     0, 1, 0, 100, 100, 100);
    av("unlock5",    UNL, 5,   0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("relock",     LCK, 5,   0, 0,     0,     0,              0, 0,     0,         0,     0, 1, 0, 100, 100, 100);
    av("rnd1",       NOP, 0,   1, 0,     0,     0,              0, 0,     0,         0,     0, 0, 0, 100, 100, 100);
    av("bids3",      NOP, 0,   1, 3'b111, 0,    a3(20, 30, 10), 0, 3'b111, 0,        0,     0, 0, 0, 99,  99,  99);
    av("rnd1_end",   NOP, 0,   0, 0,     0,     0,              0, 0,     0,         0,     0, 0, 0, 99,  99,  99);
    av("result1",    NOP, 0,   0, 0,     0,     0,              0, 0,     0,         3'b010, 30, 1, 1, 99, 69,  99);
    av("hold1",      NOP, 0,   0, 0,     0,     0,              0, 0,     0,         3'b010, 30, 1, 0, 99, 69,  99);
    av("unl_b",      UNL, 5,   0, 0,     0,     0,              0, 0,     0,         3'b010, 30, 1, 0, 99, 69,  99);
    av("sel0b",      SEL, 0,   0, 0,     0,     0,              0, 0,     0,         3'b010, 30, 1, 0, 99, 69,  99);
    av("ld10",       LDB, 10,  0, 0,     0,     0,              0, 0,     0,         3'b010, 30, 1, 0, 10, 69,  99);
    av("mask101",    MSK, 5,   0, 0,     0,     0,              0, 0,     0,         3'b010, 30, 1, 0, 10, 69,  99);
    av("lock7",      LCK, 7,   0, 0,     0,     0,              0, 0,     0,         3'b010, 30, 1, 0, 10, 69,  99);
    av("rnd2",       NOP, 0,   1, 0,     0,     0,              0, 0,     0,         0,     30, 0, 0, 10, 69,  99);
    av("poor_bid",   NOP, 0,   1, 3'b001, 0,    a3(0, 0, 10),   0, 0,     6'b000010, 0,     30, 0, 0, 10, 69,  99);
    av("ok_bid",     NOP, 0,   1, 3'b001, 0,    a3(0, 0, 9),    0, 3'b001, 0,        0,     30, 0, 0, 9,  69,  99);
    av("mask_ret",   NOP, 0,   1, 3'b110, 3'b100, a3(7, 5, 0),  0, 0,     6'b001100, 0,     30, 0, 0, 9,  69,  99);
    av("rnd2_end",   NOP, 0,   0, 0,     0,     0,              0, 0,     0,         0,     30, 0, 0, 9,  69,  99);
    av("result2",    NOP, 0,   0, 3'b100, 0,    0,              0, 0,     6'b010000, 3'b001, 9, 1, 1, 0,  69,  99);
    av("unl7",       UNL, 7,   0, 0,     0,     0,              0, 0,     0,         3'b001, 9, 1, 0, 0,  69,  99);
    av("ld100",      LDB, 100, 0, 0,     0,     0,              0, 0,     0,         3'b001, 9, 1, 0, 100, 69, 99);
    av("lock1",      LCK, 1,   0, 0,     0,     0,              0, 0,     0,         3'b001, 9, 1, 0, 100, 69, 99);
    av("rnd3",       NOP, 0,   1, 0,     0,     0,              0, 0,     0,         0,     9,  0, 0, 100, 69, 99);
    av("tie_bids",   NOP, 0,   1, 3'b101, 0,    a3(40, 0, 40),  0, 3'b101, 0,        0,     9,  0, 0, 99,  69, 98);
    av("rnd3_end",   NOP, 0,   0, 0,     0,     0,              0, 0,     0,         0,     9,  0, 0, 99,  69, 98);
    av("tie",        NOP, 0,   0, 0,     0,     0,              5, 0,     0,         0,     40, 1, 1, 99,  69, 98);
    av("unl1",       UNL, 1,   0, 0,     0,     0,              0, 0,     0,         0,     40, 1, 0, 99,  69, 98);
    av("timer4",     TMR, 4,   0, 0,     0,     0,              0, 0,     0,         0,     40, 1, 0, 99,  69, 98);
    av("lock2",      LCK, 2,   0, 0,     0,     0,              0, 0,     0,         0,     40, 1, 0, 99,  69, 98);
    av("rnd4",       NOP, 0,   1, 0,     0,     0,              0, 0,     0,         0,     40, 0, 0, 99,  69, 98);
    av("t_bid",      NOP, 0,   1, 3'b100, 0,    a3(50, 0, 0),   0, 3'b100, 0,        0,     40, 0, 0, 99,  69, 97);
    av("t_ret",      NOP, 0,   1, 0,     3'b100, 0,             0, 0,     0,         0,     40, 0, 0, 99,  69, 97);
    av("t_wait",     NOP, 0,   1, 0,     0,     0,              0, 0,     0,         0,     40, 0, 0, 99,  69, 97);
    av("t_exit",     NOP, 0,   1, 0,     0,     0,              0, 0,     0,         0,     40, 0, 0, 99,  69, 97);
    av("t_result",   NOP, 0,   1, 0,     0,     0,              0, 0,     0,         0,     0,  1, 1, 99,  69, 97);
    av("t_idle",     NOP, 0,   0, 0,     0,     0,              0, 0,     0,         0,     0,  1, 0, 99,  69, 97);

    repeat (2) @(posedge clk);
    #1;
    rst3_n = 1'b1;
    chk("rst.ready", 64'(if3.ready), 64'd0);
    chk("rst.err",   64'(if3.err), 64'd0);
    chk("rst.win",   64'(if3.win), 64'd0);
    chk("rst.ack",   64'(if3.ack), 64'd0);
    chk("rst.bal0",  64'(if3.balance[31:0]), 64'd0);

    foreach (vq[k]) begin
      vec_t v;
      v = vq[k];
      if3.c_op = v.op; if3.c_data = v.d; if3.c_start = v.st;
      if3.bid = v.b; if3.retract = v.r; if3.bid_amt = v.amt;
      tick();
      chk($sformatf("%s.err", v.nm),   64'(if3.err),        64'(v.e));
      chk($sformatf("%s.ack", v.nm),   64'(if3.ack),        64'(v.ak));
      chk($sformatf("%s.berr", v.nm),  64'(if3.bidder_err), 64'(v.be));
      chk($sformatf("%s.win", v.nm),   64'(if3.win),        64'(v.w));
      chk($sformatf("%s.max", v.nm),   64'(if3.max_bid),    64'(v.mb));
      chk($sformatf("%s.ready", v.nm), 64'(if3.ready),      64'(v.rd));
      chk($sformatf("%s.rover", v.nm), 64'(if3.round_over), 64'(v.ro));
      chk($sformatf("%s.bal0", v.nm),  64'(if3.balance[31:0]),  64'(v.b0));
      chk($sformatf("%s.bal1", v.nm),  64'(if3.balance[63:32]), 64'(v.b1));
      chk($sformatf("%s.bal2", v.nm),  64'(if3.balance[95:64]), 64'(v.b2));
    end
    if3.c_op = NOP; if3.c_start = 1'b0; if3.bid = '0; if3.retract = '0;

    // Eight-bidder instance: highest bidder wins at the top of the amount range
    rst8_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive8(SEL, i, 1'b0, 8'h00, 64'h0); tick();
      drive8(LDB, 1000, 1'b0, 8'h00, 64'h0); tick();
    end
    chk("n8.load7", 64'(if8.balance[7*16 +: 16]), 64'd1000);
    drive8(LCK, 3, 1'b0, 8'h00, 64'h0); tick();
    drive8(NOP, 0, 1'b1, 8'h00, 64'h0); tick();
    chk("n8.ready_round", 64'(if8.ready), 64'd0);
    drive8(NOP, 0, 1'b1, 8'hFF, 64'hFFFE_FEFE_FEFE_FEFE); tick();
    chk("n8.ack", 64'(if8.ack), 64'hFF);
    chk("n8.bal0", 64'(if8.balance[15:0]), 64'd999);
    drive8(NOP, 0, 1'b0, 8'h00, 64'h0); tick();
    tick();
    chk("n8.round_over", 64'(if8.round_over), 64'd1);
    chk("n8.win", 64'(if8.win), 64'h80);
    chk("n8.max", 64'(if8.max_bid), 64'd255);
    chk("n8.bal7", 64'(if8.balance[7*16 +: 16]), 64'd744);
    chk("n8.bal6", 64'(if8.balance[6*16 +: 16]), 64'd999);
    chk("n8.err", 64'(if8.err), 64'd0);

    // Start another round, take one bid, then pull reset between clock edges
    drive8(NOP, 0, 1'b1, 8'h00, 64'h0); tick();
    drive8(NOP, 0, 1'b1, 8'h01, 64'h0000_0000_0000_0001); tick();
    chk("n8.pre_ack", 64'(if8.ack), 64'h01);
    chk("n8.pre_bal0", 64'(if8.balance[15:0]), 64'd998);
    rst8_n = 1'b0;
    #1;
    chk("n8.arst_ack",   64'(if8.ack), 64'd0);
    chk("n8.arst_berr",  64'(if8.bidder_err), 64'd0);
    chk("n8.arst_win",   64'(if8.win), 64'd0);
    chk("n8.arst_max",   64'(if8.max_bid), 64'd0);
    chk("n8.arst_ready", 64'(if8.ready), 64'd0);
    chk("n8.arst_rover", 64'(if8.round_over), 64'd0);
    chk("n8.arst_err",   64'(if8.err), 64'd0);
    chk("n8.arst_bal_lo", if8.balance[63:0], 64'd0);
    chk("n8.arst_bal_hi", if8.balance[127:64], 64'd0);
    drive8(NOP, 0, 1'b0, 8'h00, 64'h0);
    tick();
    rst8_n = 1'b1;
    tick();
    chk("n8.post_ready", 64'(if8.ready), 64'd1);
    chk("n8.post_bal0", 64'(if8.balance[15:0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
